// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the MIPS32 instruction fetch stage.
package fetch_stage_pkg;
  localparam logic [1:0]  PC_SRC_NEXT   = 2'b00;
  localparam logic [1:0]  PC_SRC_JUMP   = 2'b01;
  localparam logic [1:0]  PC_SRC_BRANCH = 2'b10;
  localparam logic [1:0]  PC_SRC_JR     = 2'b11;
  localparam logic [31:0] INSTR_NOP     = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_HOLD  = 2'b10
  } fetch_state_t;

  function automatic logic [31:0] pc_select(input logic [1:0]  sel,
                                            input logic [31:0] plus4,
                                            input logic [31:0] jump,
                                            input logic [31:0] branch,
                                            input logic [31:0] jr);
    logic [31:0] t;
    case (sel)
      PC_SRC_JUMP:   t = jump;
      PC_SRC_BRANCH: t = branch;
      PC_SRC_JR:     t = jr;
      default:       t = plus4;
    endcase
    return t & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: squash beats load, otherwise contents hold.
module if_id_register
  import fetch_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        squash,
  input  logic [31:0] next_instruction,
  input  logic [31:0] next_pc_plus4,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        valid
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instruction <= INSTR_NOP;
      pc_plus4    <= 32'h0;
      valid       <= 1'b0;
    end else if (squash) begin
      instruction <= INSTR_NOP;
      valid       <= 1'b0;
    end else if (load) begin
      instruction <= next_instruction;
      pc_plus4    <= next_pc_plus4;
      valid       <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// MIPS32 fetch stage: PC, imem handshake, hold buffer, pending redirect.
// FETCH_DELAY_SLOT_EN defined: the word after a branch/jump is delivered valid.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_stall,
  input  logic [1:0]  id_pc_source_sel,
  input  logic        id_branch_delay_slot,
  input  logic [31:0] id_jump_target,
  input  logic [31:0] id_branch_target,
  input  logic [31:0] id_jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);
  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next, pc_plus4, hold_buf, pend_target, pend_target_next;
  logic [31:0]  redir_target, retire_word;
  logic         pend_redirect, pend_next, redirect, retire, capture;
  logic         ifid_load, ifid_squash;

  assign pc_plus4     = pc + 32'd4;
  assign redirect     = id_branch_delay_slot & if_id_valid & ~id_stall;
  assign redir_target = pc_select(id_pc_source_sel, pc_plus4, id_jump_target,
                                  id_branch_target, id_jr_target);

  // A word "retires" when it leaves IF for IF/ID; the PC only advances then.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    pend_next        = pend_redirect;
    pend_target_next = pend_target;
    retire           = 1'b0;
    capture          = 1'b0;
    ifid_load        = 1'b0;
    ifid_squash      = 1'b0;
    retire_word      = hold_buf;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        retire_word = imem_rdata;
        if (imem_ready && !id_stall) begin
          retire = 1'b1;
        end else if (imem_ready) begin
          capture    = 1'b1;
          state_next = S_HOLD;
        end else if (!id_stall) begin
          // ID consumed its instruction but nothing arrived: insert a bubble
          ifid_squash = 1'b1;
          if (redirect) begin
            pend_next        = 1'b1;
            pend_target_next = redir_target;
          end
        end
      end
      S_HOLD: begin
        if (!id_stall) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (retire) begin
      pend_next = 1'b0;
      pc_next   = redirect ? redir_target : (pend_redirect ? pend_target : pc_plus4);
`ifdef FETCH_DELAY_SLOT_EN
      ifid_load = 1'b1;
`else
      if (redirect || pend_redirect) ifid_squash = 1'b1;
      else                           ifid_load   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      pc            <= RESET_VECTOR;
      imem_req      <= 1'b0;
      pend_redirect <= 1'b0;
      pend_target   <= 32'h0;
      hold_buf      <= INSTR_NOP;
    end else begin
      state         <= state_next;
      pc            <= pc_next;
      imem_req      <= (state_next == S_FETCH);
      pend_redirect <= pend_next;
      pend_target   <= pend_target_next;
      if (capture) hold_buf <= imem_rdata;
    end
  end

  assign imem_addr = pc;
  assign if_pc     = pc;

  if_id_register u_if_id (
    .clock            (clock),
    .reset            (reset),
    .load             (ifid_load),
    .squash           (ifid_squash),
    .next_instruction (retire_word),
    .next_pc_plus4    (pc_plus4),
    .instruction      (if_id_instruction),
    .pc_plus4         (if_id_pc_plus4),
    .valid            (if_id_valid)
  );

  // ID holds a delay-slot or squashed instruction while a redirect is pending
  assert property (@(posedge clock) disable iff (reset) !(redirect && pend_redirect));
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns {16'hC0DE, addr[15:0]}.
module tb_fetch_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        id_stall, id_branch_delay_slot, imem_ready;
  logic [1:0]  id_pc_source_sel;
  logic [31:0] id_jump_target, id_branch_target, id_jr_target;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, imem_rdata, if_pc, if_id_instruction, if_id_pc_plus4;
  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clock(clock), .reset(reset), .id_stall(id_stall),
    .id_pc_source_sel(id_pc_source_sel), .id_branch_delay_slot(id_branch_delay_slot),
    .id_jump_target(id_jump_target), .id_branch_target(id_branch_target),
    .id_jr_target(id_jr_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_pc(if_pc),
    .if_id_instruction(if_id_instruction), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid)
  );

  always #5 clock = ~clock;
  assign imem_rdata = imem_ready ? {16'hC0DE, imem_addr[15:0]} : 32'hBAD0_BAD0;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Reset, release, and step past the first edge so fetch of RESET_VECTOR is outstanding.
  task automatic restart();
    reset = 1'b1; id_stall = 1'b0; id_branch_delay_slot = 1'b0; imem_ready = 1'b0;
    id_pc_source_sel = 2'b00; id_jump_target = 32'h0; id_branch_target = 32'h0;
    id_jr_target = 32'h0;
    tick(); reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; id_stall = 1'b0; id_branch_delay_slot = 1'b0; imem_ready = 1'b0;
    id_pc_source_sel = 2'b00; id_jump_target = 32'h0; id_branch_target = 32'h0;
    id_jr_target = 32'h0;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", if_id_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", if_pc); end
    checks++; if (if_id_instruction !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", if_id_instruction); end
    checks++; if (if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h want 0", if_id_pc_plus4); end
    reset = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL edge1_req got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL edge1_addr got %h want 0", imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL edge1_valid got %b want 0", if_id_valid); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_addr [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
    logic [31:0] exp_ins  [4] = '{32'hC0DE_0000, 32'hC0DE_0004, 32'hC0DE_0008, 32'hC0DE_000C};
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (if_id_instruction !== exp_ins[i]) begin errors++; $display("FAIL zw_instr[%0d] got %h want %h", i, if_id_instruction, exp_ins[i]); end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d] got %b want 1", i, if_id_valid); end
      checks++; if (if_id_pc_plus4 !== exp_addr[i]) begin errors++; $display("FAIL zw_pc4[%0d] got %h want %h", i, if_id_pc_plus4, exp_addr[i]); end
      checks++; if (imem_addr !== exp_addr[i]) begin errors++; $display("FAIL zw_addr[%0d] got %h want %h", i, imem_addr, exp_addr[i]); end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] a [2] = '{32'h10, 32'h14};
    logic [31:0] w [2] = '{32'hC0DE_0010, 32'hC0DE_0014};
    for (int k = 0; k < 2; k++) begin
      imem_ready = 1'b0;
      for (int j = 0; j < 3; j++) begin
        tick();
        checks++; if (imem_addr !== a[k]) begin errors++; $display("FAIL ws_addr[%0d.%0d] got %h want %h", k, j, imem_addr, a[k]); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL ws_req[%0d.%0d] got %b want 1", k, j, imem_req); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL ws_valid[%0d.%0d] got %b want 0", k, j, if_id_valid); end
      end
      imem_ready = 1'b1;
      tick();
      checks++; if (if_id_instruction !== w[k]) begin errors++; $display("FAIL ws_instr[%0d] got %h want %h", k, if_id_instruction, w[k]); end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL ws_done_valid[%0d] got %b want 1", k, if_id_valid); end
    end
    imem_ready = 1'b0;
  endtask

  task automatic test_stall_hold();
    restart();
    imem_ready = 1'b1;
    tick(); tick();
    id_stall = 1'b1;
    tick();
    imem_ready = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req got %b want 0", imem_req); end
    checks++; if (if_pc !== 32'h8) begin errors++; $display("FAIL hold_pc got %h want 8", if_pc); end
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d] got %b want 0", j, imem_req); end
      checks++; if (if_id_instruction !== 32'hC0DE_0004) begin errors++; $display("FAIL hold_ifid[%0d] got %h want c0de0004", j, if_id_instruction); end
    end
    id_stall = 1'b0;
    tick();
    checks++; if (if_id_instruction !== 32'hC0DE_0008) begin errors++; $display("FAIL unhold_instr got %h want c0de0008", if_id_instruction); end
    checks++; if (if_id_pc_plus4 !== 32'hC) begin errors++; $display("FAIL unhold_pc4 got %h want c", if_id_pc_plus4); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL unhold_req got %b/%h want 1/c", imem_req, imem_addr); end
    imem_ready = 1'b1;
    tick();
    checks++; if (if_id_instruction !== 32'hC0DE_000C) begin errors++; $display("FAIL after_hold_instr got %h want c0de000c", if_id_instruction); end
  endtask

  task automatic test_branch();
    restart();
    imem_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (if_id_instruction !== 32'hC0DE_0010) begin errors++; $display("FAIL br_setup got %h want c0de0010", if_id_instruction); end
    id_branch_delay_slot = 1'b1; id_pc_source_sel = 2'b10; id_branch_target = 32'h40;
    tick();
    id_branch_delay_slot = 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
    checks++; if (if_id_valid !== 1'b1 || if_id_instruction !== 32'hC0DE_0014) begin errors++; $display("FAIL br_slot got %b/%h want 1/c0de0014", if_id_valid, if_id_instruction); end
`else
    checks++; if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0) begin errors++; $display("FAIL br_squash got %b/%h want 0/0", if_id_valid, if_id_instruction); end
`endif
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL br_addr got %h want 40", imem_addr); end
    tick();
    checks++; if (if_id_instruction !== 32'hC0DE_0040 || if_id_valid !== 1'b1) begin errors++; $display("FAIL br_target got %b/%h want 1/c0de0040", if_id_valid, if_id_instruction); end
    checks++; if (imem_addr !== 32'h44) begin errors++; $display("FAIL br_next got %h want 44", imem_addr); end
  endtask

  task automatic test_pending_jr();
    restart();
    imem_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    imem_ready = 1'b0;
    id_branch_delay_slot = 1'b1; id_pc_source_sel = 2'b11; id_jr_target = 32'h100;
    tick();
    id_branch_delay_slot = 1'b0;
    checks++; if (imem_addr !== 32'h14 || if_id_valid !== 1'b0) begin errors++; $display("FAIL jr_wait1 got %h/%b want 14/0", imem_addr, if_id_valid); end
    tick();
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL jr_wait2 got %h want 14", imem_addr); end
    imem_ready = 1'b1;
    tick();
`ifdef FETCH_DELAY_SLOT_EN
    checks++; if (if_id_valid !== 1'b1 || if_id_instruction !== 32'hC0DE_0014) begin errors++; $display("FAIL jr_slot got %b/%h want 1/c0de0014", if_id_valid, if_id_instruction); end
`else
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL jr_squash got %b want 0", if_id_valid); end
`endif
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL jr_addr got %h want 100", imem_addr); end
    tick();
    checks++; if (if_id_instruction !== 32'hC0DE_0100 || if_id_pc_plus4 !== 32'h104) begin errors++; $display("FAIL jr_target got %h/%h want c0de0100/104", if_id_instruction, if_id_pc_plus4); end
    checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL jr_next got %h want 104", imem_addr); end
  endtask

  task automatic test_wrap();
    restart();
    imem_ready = 1'b1;
    tick();
    id_branch_delay_slot = 1'b1; id_pc_source_sel = 2'b01; id_jump_target = 32'hFFFF_FFFC;
    tick();
    id_branch_delay_slot = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_jaddr got %h want fffffffc", imem_addr); end
    tick();
    checks++; if (if_id_instruction !== 32'hC0DE_FFFC) begin errors++; $display("FAIL wrap_instr got %h want c0defffc", if_id_instruction); end
    checks++; if (if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h want 0", if_id_pc_plus4); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_reset_mid();
    restart();
    imem_ready = 1'b1;
    tick(); tick();
    imem_ready = 1'b0; id_stall = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || if_id_valid !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL mid_pre got %b/%b/%h want 1/1/8", imem_req, if_id_valid, imem_addr); end
    #2 reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_req got %b want 0", imem_req); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", if_id_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL mid_pc got %h want 0", if_pc); end
    tick();
    reset = 1'b0; id_stall = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_refetch got %b/%h want 1/0", imem_req, imem_addr); end
    imem_ready = 1'b1;
    tick();
    checks++; if (if_id_instruction !== 32'hC0DE_0000 || if_id_valid !== 1'b1) begin errors++; $display("FAIL mid_first got %b/%h want 1/c0de0000", if_id_valid, if_id_instruction); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_hold();
    test_branch();
    test_pending_jr();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
